// File: rtl/fc_pkg.sv
// Shared definitions for the FC1 scheduler: FSM encoding, default layer shape, address widths.
// Weight addressing helper: flat index grp*N_IN+k, computed unsigned and truncated to the port width.
package fc_pkg;

  localparam int N_IN_DEF  = 100;
  localparam int N_GRP_DEF = 3;
  localparam int FEAT_AW   = 7;
  localparam int WGT_AW    = 9;
  localparam int GRP_W     = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FEED   = 3'd2,
    S_DRAIN  = 3'd3,
    S_OUTPUT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  function automatic logic [WGT_AW-1:0] wgt_addr(
    input logic [GRP_W-1:0]   grp,
    input logic [FEAT_AW-1:0] k,
    input int                 n_in
  );
    logic [31:0] w_sum;
    w_sum = 32'(grp) * 32'(unsigned'(n_in)) + 32'(k);
    return w_sum[WGT_AW-1:0];
  endfunction

endpackage

// File: rtl/delay_line.sv
// 1-bit delay line of DEPTH cycles (DEPTH >= 1); synchronous clear flushes all stages at once.
// No backpressure: one bit in and one bit out every cycle.
module delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (i_clr) begin
      r_sr <= '0;
    end else begin
      r_sr <= (r_sr << 1) | DEPTH'(i_d);
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/fc1_scheduler.sv
// FC1 layer scheduler: per group of 4 neurons, CLEAR(1) + FEED(N_IN) + DRAIN(RD_LAT+MUL_LAT+1) + OUTPUT(>=1),
// then a one-cycle DONE. Results are held in OUTPUT until i_res_ready; i_abort wins over everything.
module fc1_scheduler
  import fc_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int N_IN      = N_IN_DEF,
  parameter int N_GRP     = N_GRP_DEF,
  parameter int RD_LAT    = 1,
  parameter int MUL_LAT   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  output logic               o_busy,
  output logic               o_feat_rd,
  output logic [FEAT_AW-1:0] o_feat_addr,
  output logic               o_wgt_rd,
  output logic [WGT_AW-1:0]  o_wgt_addr,
  output logic               o_acc_clr,
  output logic               o_acc_en,
  output logic [GRP_W-1:0]   o_grp,
  output logic               o_res_valid,
  input  logic               i_res_ready,
  output logic               o_done
);

  localparam int PIPE_LAT  = RD_LAT + MUL_LAT;
  localparam int DRAIN_LEN = PIPE_LAT + 1;
  localparam int DCNT_W    = $clog2(DRAIN_LEN + 1);

  localparam logic [FEAT_AW-1:0] K_LAST = FEAT_AW'(N_IN - 1);
  localparam logic [DCNT_W-1:0]  D_LAST = DCNT_W'(DRAIN_LEN - 1);
  localparam logic [GRP_W-1:0]   G_LAST = GRP_W'(N_GRP - 1);

  if (WORD_SIZE < 1 || N_IN < 1 || N_IN > (1 << FEAT_AW) || N_GRP < 1 ||
      N_GRP > (1 << GRP_W) || N_GRP * N_IN > (1 << WGT_AW) ||
      RD_LAT < 0 || MUL_LAT < 0 || PIPE_LAT < 1) begin : g_cfg_err
    $error("fc1_scheduler: unsupported parameter combination");
  end

  state_t                r_state;
  state_t                w_next;
  logic [FEAT_AW-1:0]    r_k;
  logic [DCNT_W-1:0]     r_dcnt;
  logic [GRP_W-1:0]      r_grp;
  logic                  w_feed;

  assign w_feed = (r_state == S_FEED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start)          w_next = S_CLEAR;
      S_CLEAR:                        w_next = S_FEED;
      S_FEED:   if (r_k == K_LAST)    w_next = S_DRAIN;
      S_DRAIN:  if (r_dcnt == D_LAST) w_next = S_OUTPUT;
      S_OUTPUT: if (i_res_ready)      w_next = (r_grp == G_LAST) ? S_DONE : S_CLEAR;
      S_DONE:                         w_next = S_IDLE;
      default:                        w_next = S_IDLE;
    endcase
    if (i_abort) begin
      w_next = S_IDLE;
    end
  end

  // k indexes activations in FEED; r_dcnt times the drain window; both rest at 0 elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k    <= '0;
      r_dcnt <= '0;
      r_grp  <= '0;
    end else if (i_abort) begin
      r_k    <= '0;
      r_dcnt <= '0;
      r_grp  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_k    <= '0;
          r_dcnt <= '0;
          r_grp  <= '0;
        end
        S_FEED:   r_k    <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
        S_DRAIN:  r_dcnt <= (r_dcnt == D_LAST) ? '0 : r_dcnt + 1'b1;
        S_OUTPUT: if (i_res_ready && (r_grp != G_LAST)) r_grp <= r_grp + 1'b1;
        S_DONE:   r_grp  <= '0;
        default:  ;
      endcase
    end
  end

  delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_acc_en_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (i_abort),
    .i_d   (w_feed),
    .o_q   (o_acc_en)
  );

  always_comb begin
    o_busy      = (r_state != S_IDLE);
    o_acc_clr   = (r_state == S_CLEAR);
    o_feat_rd   = w_feed;
    o_wgt_rd    = w_feed;
    o_feat_addr = w_feed ? r_k : '0;
    o_wgt_addr  = w_feed ? wgt_addr(r_grp, r_k, N_IN) : '0;
    o_grp       = r_grp;
    o_res_valid = (r_state == S_OUTPUT);
    o_done      = (r_state == S_DONE);
  end

endmodule

// File: tb/tb_fc1_scheduler.sv
// Bench for fc1_scheduler: a per-group cycle-offset model checked every cycle, plus directed scenarios
// with literal expectations (layer length, group-2 addresses, held results, ignored start, abort, reset).
module tb_fc1_scheduler;

  localparam int N_IN      = 100;
  localparam int N_GRP     = 3;
  localparam int D         = 2;
  localparam int DRAIN_LEN = D + 1;
  localparam int OUT_T     = 1 + N_IN + DRAIN_LEN;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic       i_abort;
  logic       i_res_ready;
  logic       o_busy;
  logic       o_feat_rd;
  logic [6:0] o_feat_addr;
  logic       o_wgt_rd;
  logic [8:0] o_wgt_addr;
  logic       o_acc_clr;
  logic       o_acc_en;
  logic [1:0] o_grp;
  logic       o_res_valid;
  logic       o_done;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: a running layer is a group index plus a cycle offset t inside that group.
  int m_run  = 0;
  int m_grp  = 0;
  int m_t    = 0;
  int m_done = 0;

  int cnt_clr = 0, cnt_rd = 0, cnt_acc = 0, cnt_done = 0, cnt_rv = 0, last_done_cyc = 0;
  int g2_fw = -1, g2_lw = -1, g2_ff = -1, g2_lf = -1;

  fc1_scheduler u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .o_busy      (o_busy),
    .o_feat_rd   (o_feat_rd),
    .o_feat_addr (o_feat_addr),
    .o_wgt_rd    (o_wgt_rd),
    .o_wgt_addr  (o_wgt_addr),
    .o_acc_clr   (o_acc_clr),
    .o_acc_en    (o_acc_en),
    .o_grp       (o_grp),
    .o_res_valid (o_res_valid),
    .i_res_ready (i_res_ready),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0; m_grp <= 0; m_t <= 0; m_done <= 0;
    end else if (i_abort) begin
      m_run <= 0; m_grp <= 0; m_t <= 0; m_done <= 0;
    end else if (m_done != 0) begin
      m_done <= 0; m_grp <= 0;
    end else if (m_run == 0) begin
      if (i_start) begin
        m_run <= 1; m_grp <= 0; m_t <= 0;
      end
    end else if (m_t == OUT_T) begin
      if (i_res_ready) begin
        if (m_grp == N_GRP - 1) begin
          m_run <= 0; m_done <= 1;
        end else begin
          m_grp <= m_grp + 1; m_t <= 0;
        end
      end
    end else begin
      m_t <= m_t + 1;
    end
  end

  initial begin
    int e_rd, e_acc;
    forever begin
      @(negedge clk);
      e_rd  = (m_run != 0 && m_t >= 1 && m_t <= N_IN) ? 1 : 0;
      e_acc = (m_run != 0 && m_t >= 1 + D && m_t <= N_IN + D) ? 1 : 0;
      chk("busy",      int'(o_busy),      (m_run != 0 || m_done != 0) ? 1 : 0);
      chk("acc_clr",   int'(o_acc_clr),   (m_run != 0 && m_t == 0) ? 1 : 0);
      chk("feat_rd",   int'(o_feat_rd),   e_rd);
      chk("wgt_rd",    int'(o_wgt_rd),    e_rd);
      chk("feat_addr", int'(o_feat_addr), (e_rd != 0) ? m_t - 1 : 0);
      chk("wgt_addr",  int'(o_wgt_addr),  (e_rd != 0) ? m_grp * N_IN + m_t - 1 : 0);
      chk("acc_en",    int'(o_acc_en),    e_acc);
      chk("grp",       int'(o_grp),       m_grp);
      chk("res_valid", int'(o_res_valid), (m_run != 0 && m_t == OUT_T) ? 1 : 0);
      chk("done",      int'(o_done),      m_done);
      if (o_acc_clr)   cnt_clr  = cnt_clr + 1;
      if (o_feat_rd)   cnt_rd   = cnt_rd + 1;
      if (o_acc_en)    cnt_acc  = cnt_acc + 1;
      if (o_res_valid) cnt_rv   = cnt_rv + 1;
      if (o_done) begin
        cnt_done      = cnt_done + 1;
        last_done_cyc = cyc;
      end
      if (o_feat_rd && o_grp == 2'd2) begin
        if (g2_fw < 0) begin
          g2_fw = int'(o_wgt_addr);
          g2_ff = int'(o_feat_addr);
        end
        g2_lw = int'(o_wgt_addr);
        g2_lf = int'(o_feat_addr);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n0;
    int i;
    n0 = cnt_done;
    i  = 0;
    while (cnt_done == n0 && i < budget) begin
      step(1);
      i++;
    end
    chk(name, (cnt_done != n0) ? 1 : 0, 1);
  endtask

  task automatic wait_k(input string name, input int k);
    int i;
    i = 0;
    while (!(o_feat_rd && int'(o_feat_addr) == k) && i < 400) begin
      step(1);
      i++;
    end
    chk(name, o_feat_rd ? int'(o_feat_addr) : -1, k);
  endtask

  task automatic pulse_start(output int sc);
    i_start = 1'b1;
    sc      = cyc;
    step(1);
    i_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, failures so far %0d", n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int sc, c0, r0, a0, d0, rv0, i;
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_res_ready = 1'b1;
    step(2);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_addr", int'(o_wgt_addr), 0);
    chk("rst_acc_en", int'(o_acc_en), 0);
    rst_n = 1'b1;
    step(2);

    // Full layer with ready tied high.
    c0 = cnt_clr; r0 = cnt_rd; a0 = cnt_acc; d0 = cnt_done;
    pulse_start(sc);
    wait_done("A_done_seen", 400);
    chk("A_done_cycle", last_done_cyc - sc, 316);
    chk("A_clr_count", cnt_clr - c0, 3);
    chk("A_rd_count", cnt_rd - r0, 300);
    chk("A_acc_count", cnt_acc - a0, 300);
    chk("A_done_count", cnt_done - d0, 1);
    chk("A_g2_wgt_first", g2_fw, 200);
    chk("A_g2_wgt_last", g2_lw, 299);
    chk("A_g2_feat_first", g2_ff, 0);
    chk("A_g2_feat_last", g2_lf, 99);
    step(3);

    // Results held while downstream stalls for 5 cycles.
    i_res_ready = 1'b0;
    pulse_start(sc);
    i = 0;
    while (!o_res_valid && i < 200) begin
      step(1);
      i++;
    end
    chk("B_valid_seen", int'(o_res_valid), 1);
    rv0 = cnt_rv;
    step(5);
    chk("B_valid_held", int'(o_res_valid), 1);
    chk("B_grp_held", int'(o_grp), 0);
    i_res_ready = 1'b1;
    step(1);
    chk("B_valid_cycles", cnt_rv - rv0, 6);
    chk("B_grp_next", int'(o_grp), 1);
    chk("B_clear_after", int'(o_acc_clr), 1);
    wait_done("B_done_seen", 400);
    step(2);

    // Start during FEED is ignored.
    d0 = cnt_done;
    pulse_start(sc);
    wait_k("C_reach_k10", 10);
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
    wait_done("C_done_seen", 400);
    chk("C_done_cycle", last_done_cyc - sc, 316);
    step(350);
    chk("C_single_done", cnt_done - d0, 1);
    chk("C_idle", int'(o_busy), 0);

    // Abort mid-FEED, then a clean rerun.
    d0 = cnt_done;
    pulse_start(sc);
    wait_k("D_reach_k50", 50);
    i_abort = 1'b1;
    step(1);
    i_abort = 1'b0;
    chk("D_busy_after_abort", int'(o_busy), 0);
    chk("D_acc_en_after_abort", int'(o_acc_en), 0);
    chk("D_grp_after_abort", int'(o_grp), 0);
    step(20);
    chk("D_no_done", cnt_done - d0, 0);
    c0 = cnt_clr; r0 = cnt_rd; a0 = cnt_acc;
    pulse_start(sc);
    chk("D_restart_grp", int'(o_grp), 0);
    chk("D_restart_clr", int'(o_acc_clr), 1);
    wait_done("D_rerun_done", 400);
    chk("D_rerun_cycle", last_done_cyc - sc, 316);
    chk("D_rerun_rd", cnt_rd - r0, 300);
    chk("D_rerun_acc", cnt_acc - a0, 300);
    step(2);

    // Asynchronous reset in DRAIN clears outputs before the next edge.
    pulse_start(sc);
    wait_k("E_reach_k99", 99);
    step(1);
    chk("E_drain_acc_en", int'(o_acc_en), 1);
    chk("E_drain_busy", int'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("E_rst_busy", int'(o_busy), 0);
    chk("E_rst_acc_en", int'(o_acc_en), 0);
    chk("E_rst_grp", int'(o_grp), 0);
    chk("E_rst_valid", int'(o_res_valid), 0);
    chk("E_rst_done", int'(o_done), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(2);
    chk("E_idle_after_rst", int'(o_busy), 0);
    pulse_start(sc);
    wait_done("E_rerun_done", 400);
    chk("E_rerun_cycle", last_done_cyc - sc, 316);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fc1_scheduler.md
FC1_SCHEDULER -- requirements
Module: fc1_scheduler

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, datapath word is WORD_SIZE+1 bits (informational; no data ports).
REQ-002 SHALL have parameter N_IN, default 100, input activations per neuron.
REQ-003 SHALL have parameter N_GRP, default 3, groups of 4 output neurons.
REQ-004 SHALL have parameter RD_LAT, default 1, feature/weight memory read latency in cycles.
REQ-005 SHALL have parameter MUL_LAT, default 1, multiplier latency in cycles.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port i_start, input, 1 bit: one-cycle request to run a full layer.
REQ-009 SHALL have port i_abort, input, 1 bit: synchronous cancel.
REQ-010 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port o_feat_rd, output, 1 bit: feature memory read strobe.
REQ-012 SHALL have port o_feat_addr, output, 7 bits: activation index 0..N_IN-1.
REQ-013 SHALL have port o_wgt_rd, output, 1 bit: weight memory read strobe, equal to o_feat_rd.
REQ-014 SHALL have port o_wgt_addr, output, 9 bits: grp*N_IN+k.
REQ-015 SHALL have port o_acc_clr, output, 1 bit: clears the four MAC accumulators.
REQ-016 SHALL have port o_acc_en, output, 1 bit: enables accumulation of the current product.
REQ-017 SHALL have port o_grp, output, 2 bits: current neuron group index.
REQ-018 SHALL have port o_res_valid, output, 1 bit: the four accumulator results of o_grp are final.
REQ-019 SHALL have port i_res_ready, input, 1 bit: downstream accepts the results.
REQ-020 SHALL have port o_done, output, 1 bit: one-cycle pulse when the layer completes.

Function
REQ-021 SHALL implement states IDLE, CLEAR, FEED, DRAIN, OUTPUT, DONE.
REQ-022 IDLE: SHALL move to CLEAR when i_start=1, with grp=0; i_start SHALL be ignored in any other state.
REQ-023 CLEAR: SHALL assert o_acc_clr for exactly one cycle, then move to FEED.
REQ-024 FEED: SHALL assert o_feat_rd/o_wgt_rd for exactly N_IN consecutive cycles with k=0..N_IN-1 and no gaps, then move to DRAIN.
REQ-025 o_acc_en SHALL equal o_feat_rd delayed by RD_LAT+MUL_LAT cycles through a shift register, giving exactly N_IN enable cycles per group.
REQ-026 DRAIN: SHALL last RD_LAT+MUL_LAT+1 cycles, the extra cycle covering the accumulator register, then move to OUTPUT.
REQ-027 OUTPUT: SHALL hold o_res_valid=1 until i_res_ready=1; on that handshake cycle it SHALL move to DONE if grp==N_GRP-1, else increment grp and move to CLEAR.
REQ-028 i_res_ready SHALL have no effect outside OUTPUT; o_res_valid SHALL NOT drop without a handshake except on abort or reset.
REQ-029 DONE: SHALL assert o_done for one cycle, then move to IDLE.
REQ-030 Address arithmetic SHALL be unsigned; o_wgt_addr SHALL NOT wrap for N_GRP*N_IN<=512.
REQ-031 i_abort=1 in any state SHALL force IDLE on the next edge, clearing grp, k, the enable shift register and o_res_valid, with no o_done; abort SHALL take priority over i_start and i_res_ready.
REQ-032 Addresses SHALL read 0 whenever their strobe is low.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE, grp=0, k=0, the shift register to 0 and all outputs to 0.
REQ-034 Reset mid-layer SHALL discard all progress; the first edge after release SHALL see IDLE.

Structure
REQ-035 State encoding, the N_IN/N_GRP defaults and address widths SHALL live in shared package fc_pkg.
REQ-036 The enable delay line SHALL be sub-module delay_line (parameter DEPTH, 1-bit, async reset); everything else SHALL be a single FSM plus counters.

Verification
REQ-037 Start with ready tied high, defaults -> 3 groups each give 1 clr, 100 rd, 100 acc_en; o_done at cycle 3*(1+100+3+1)+1 after start.
REQ-038 Group 2 -> o_wgt_addr runs 200..299 while o_feat_addr runs 0..99.
REQ-039 Ready low for 5 cycles in OUTPUT -> o_res_valid held stable 6 cycles and o_grp unchanged.
REQ-040 i_start pulsed during FEED -> ignored, with a single o_done only.
REQ-041 i_abort at k=50 -> o_busy=0 next cycle, o_acc_en drains to 0, no o_done; a new start runs cleanly from grp=0.
REQ-042 rst_n low mid-DRAIN -> all outputs 0 immediately, before the next clk edge.
